uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between two byte sources:
  - the loopback echo path, carrying bytes from the UART receiver;
  - a local message source that sends multi-byte packets.
- Sequences each transmitter start/done handshake, locks the grant for a whole message packet, and drops echo traffic when loopback is disabled.
- Recovers from a transmitter that never completes.
- Sits between the UART RX/message logic and the UART TX core inside top_uart, clocked from the 50 MHz system clock.

Parameters:
DATA_W, 8, byte width of all data paths
TX_TIMEOUT, 65535, max cycles in WAIT before abort (one byte at 115200 baud and 50 MHz is about 4340 cycles)
ERR_W, 8, width of the saturating timeout error counter

Ports:
clk  input  1  system clock (50 MHz)
rst_n  input  1  asynchronous active-low reset
loopback_en  input  1  asynchronous switch level; synchronised internally
echo_valid  input  1  echo byte available
echo_data  input  DATA_W  echo byte
echo_ready  output  1  echo byte accepted (or dropped) this cycle
msg_valid  input  1  message byte available
msg_data  input  DATA_W  message byte
msg_last  input  1  qualifies msg_data as final byte of packet
msg_ready  output  1  message byte accepted this cycle
tx_start  output  1  one-cycle start pulse to UART TX
tx_data  output  DATA_W  byte to UART TX, stable from tx_start until tx_done
tx_busy  input  1  UART TX shifting
tx_done  input  1  one-cycle pulse, byte fully sent
grant  output  2  one-hot current owner: [0]=echo, [1]=msg, 00=none
timeout_err  output  1  one-cycle pulse on abort
err_cnt  output  ERR_W  saturating abort count

Behaviour:
- Clock, reset and handshake:
  - Single clock: clk. Reset: rst_n, asynchronous active-low.
  - On reset, all outputs are 0: tx_start, tx_data, echo_ready, msg_ready, grant, timeout_err, err_cnt.
  - On reset, internal state is cleared: state=IDLE, lock=0, last_grant=msg (echo wins the first tie), loopback synchroniser=0.
  - Transfer occurs on a cycle where valid and ready are both 1. ready is combinational, only in IDLE, for at most one requester.
- Loopback gating (lb_s = two-flop synchronised loopback_en, 2-cycle latency):
  - lb_s=0: echo_ready = echo_valid in every state. Echo bytes are discarded, never transmitted, and the receiver never stalls.
  - lb_s=1: echo takes part in arbitration.
- FSM states: IDLE, START, WAIT.
  - IDLE, selection order:
    - lock=1: only msg is eligible.
    - Otherwise, if both are eligible, round-robin against last_grant.
    - Otherwise, the single eligible requester is selected.
  - IDLE, on a transfer:
    - Capture data into tx_data.
    - Set grant and last_grant.
    - For msg: lock = ~msg_last.
    - Go to START.
  - START:
    - If tx_busy=0, assert tx_start for exactly one cycle and go to WAIT.
    - Otherwise hold in START; tx_start stays 0.
  - WAIT:
    - Timeout counter runs from 0.
    - On tx_done: go to IDLE. grant is cleared to 00 only if lock=0.
    - On counter = TX_TIMEOUT-1 without tx_done:
      - Pulse timeout_err.
      - err_cnt += 1, saturating at all-ones.
      - Clear lock, clear grant, go to IDLE.
- Latency and throughput:
  - Accept in cycle N gives tx_start in cycle N+1 when tx_busy=0.
  - Minimum byte-to-byte spacing is tx_done followed by 1 IDLE cycle.
- Boundary conditions:
  - tx_done arriving in IDLE or START is ignored.
  - Echo valid during a locked message waits (ready=0) until the byte with msg_last completes.
  - lb_s falling while echo is granted: the in-flight byte completes normally; afterwards echo is dropped.
  - msg_valid falling mid-packet while locked: the arbiter stays in IDLE with lock held. There is no timeout in IDLE.
  - rst_n asserted mid-byte: everything returns immediately to reset values, and tx_start is never re-issued for the aborted byte.

Decomposition:
- Shared package uart_arb_pkg holds:
  - state enum {IDLE, START, WAIT};
  - grant constants GNT_NONE=2'b00, GNT_ECHO=2'b01, GNT_MSG=2'b10;
  - DATA_W default.
- One sub-module, sync_2ff, synchronises loopback_en; it is reusable for the other switch inputs.

Test Plan:
- Reset, lb=1, echo_valid with 0x41, tx_busy=0 -> echo_ready in cycle N, tx_start pulse in N+1 with tx_data=0x41, grant=01 until tx_done.
- Both requesters valid continuously, single bytes (msg_last=1), echo 0x11 / msg 0x22 -> transmit order 0x11,0x22,0x11,0x22.
- Msg packet 0xA0,0xA1,0xA2 (last on 0xA2) with echo 0x55 valid throughout -> order A0,A1,A2,55; grant stays 10 between bytes.
- lb=0, echo_valid high with 0x33 for 10 cycles -> echo_ready high each cycle (from 2 cycles after lb drops), no tx_start.
- tx_done withheld, TX_TIMEOUT=16 -> timeout_err pulse 16 cycles after tx_start, err_cnt=1, grant=00, next request served normally; repeat 300 times -> err_cnt saturates at 255.
- rst_n low during WAIT of a locked packet -> all outputs 0 immediately; after release, echo wins the first tie.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// ============================================================================
// Module : uart_arb_pkg
// Shared types and constants for the UART transmitter arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package uart_arb_pkg;

   localparam int DEF_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_ECHO = 2'b01;
   localparam logic [1:0] GNT_MSG  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module : sync_2ff
// Two-flop synchroniser for slow asynchronous level inputs (switches).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module : uart_tx_arbiter
// Shares one UART TX between the echo path and a packetised message source.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int TX_TIMEOUT = 65535,
   parameter int ERR_W      = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              loopback_en,
   input  logic              echo_valid,
   input  logic [DATA_W-1:0] echo_data,
   output logic              echo_ready,
   input  logic              msg_valid,
   input  logic [DATA_W-1:0] msg_data,
   input  logic              msg_last,
   output logic              msg_ready,
   output logic              tx_start,
   output logic [DATA_W-1:0] tx_data,
   input  logic              tx_busy,
   input  logic              tx_done,
   output logic [1:0]        grant,
   output logic              timeout_err,
   output logic [ERR_W-1:0]  err_cnt
);

   localparam int              CNT_W    = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TX_TIMEOUT - 1);

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   logic              w_lb_s;
   logic              r_lock;
   logic              r_last_msg;     // 1: msg was granted last, so echo wins the next tie
   logic [1:0]        r_grant;
   logic [DATA_W-1:0] r_tx_data;
   logic [CNT_W-1:0]  r_tmo;
   logic [ERR_W-1:0]  r_err;

   logic              w_echo_elig;
   logic              w_msg_elig;
   logic              w_sel_echo;
   logic              w_sel_msg;
   logic              w_tx_start;
   logic              w_done;
   logic              w_tmo_hit;

   sync_2ff #(
      .WIDTH (1)
   ) u_lb_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (loopback_en),
      .o_q   (w_lb_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sel_echo  = 1'b0;
      w_sel_msg   = 1'b0;
      w_tx_start  = 1'b0;
      w_done      = 1'b0;
      w_tmo_hit   = 1'b0;
      w_echo_elig = w_lb_s & echo_valid & ~r_lock;
      w_msg_elig  = msg_valid;

      case (r_state)
         IDLE: begin
            if (w_echo_elig && w_msg_elig) begin
               w_sel_echo = r_last_msg;
               w_sel_msg  = ~r_last_msg;
            end else begin
               w_sel_echo = w_echo_elig;
               w_sel_msg  = w_msg_elig;
            end
            if (w_sel_echo || w_sel_msg) begin
               w_state_nxt = START;
            end
         end
         START: begin
            if (!tx_busy) begin
               w_tx_start  = 1'b1;
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (tx_done) begin
               w_done      = 1'b1;
               w_state_nxt = IDLE;
            end else if (r_tmo == TMO_LAST) begin
               w_tmo_hit   = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lock     <= 1'b0;
         r_last_msg <= 1'b1;
         r_grant    <= GNT_NONE;
         r_tx_data  <= '0;
         r_tmo      <= '0;
         r_err      <= '0;
      end else begin
         if (w_sel_echo) begin
            r_tx_data  <= echo_data;
            r_grant    <= GNT_ECHO;
            r_last_msg <= 1'b0;
         end else if (w_sel_msg) begin
            r_tx_data  <= msg_data;
            r_grant    <= GNT_MSG;
            r_last_msg <= 1'b1;
            r_lock     <= ~msg_last;
         end

         if (w_tx_start) begin
            r_tmo <= '0;
         end else if (r_state == WAIT) begin
            r_tmo <= r_tmo + 1'b1;
         end

         // A locked packet keeps its grant across the inter-byte IDLE gaps
         if (w_done && !r_lock) begin
            r_grant <= GNT_NONE;
         end

         if (w_tmo_hit) begin
            r_lock  <= 1'b0;
            r_grant <= GNT_NONE;
            if (r_err != {ERR_W{1'b1}}) begin
               r_err <= r_err + 1'b1;
            end
         end
      end
   end

   // Ready terms are gated by rst_n so they read 0 while reset is held
   assign echo_ready  = rst_n & (w_lb_s ? w_sel_echo : echo_valid);
   assign msg_ready   = rst_n & w_sel_msg;
   assign tx_start    = w_tx_start;
   assign tx_data     = r_tx_data;
   assign grant       = r_grant;
   assign timeout_err = w_tmo_hit;
   assign err_cnt     = r_err;

endmodule

`default_nettype wire
